// File: rtl/fifo_rd_packer_if.sv
// Handshake and data bundle between the FIFO read port, the packer and the wide-word consumer.
// The slave modport is the packer's view; master is the surrounding environment.
interface fifo_rd_packer_if #(
  parameter int WIDTH = 8,
  parameter int LANES = 4
);
  logic                   fifo_empty_i;
  logic [WIDTH-1:0]       fifo_rdata_i;
  logic                   fifo_error_i;
  logic                   fifo_rd_en_o;
  logic                   flush_i;
  logic                   out_valid_o;
  logic                   out_ready_i;
  logic [WIDTH*LANES-1:0] out_data_o;
  logic [LANES-1:0]       out_keep_o;
  logic [7:0]             err_cnt_o;

  modport slave (
    input  fifo_empty_i, fifo_rdata_i, fifo_error_i, flush_i, out_ready_i,
    output fifo_rd_en_o, out_valid_o, out_data_o, out_keep_o, err_cnt_o
  );

  modport master (
    output fifo_empty_i, fifo_rdata_i, fifo_error_i, flush_i, out_ready_i,
    input  fifo_rd_en_o, out_valid_o, out_data_o, out_keep_o, err_cnt_o
  );
endinterface

// File: rtl/fifo_rd_packer.sv
// Drains an async FIFO read port (1-cycle read latency) and packs LANES words into one
// wide valid/ready word; flush emits a partial word with a lane-keep mask.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_FILL  | normal operation: request, capture and transfer full words
// ST_FLUSH | no new reads; wait for in-flight capture, then emit partial
module fifo_rd_packer #(
  parameter int WIDTH = 8,
  parameter int LANES = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  fifo_rd_packer_if.slave  bus
);

  typedef enum logic [0:0] {ST_FILL, ST_FLUSH} state_t;

  localparam logic [CNT_W-1:0] LANES_C = CNT_W'(LANES);
  localparam logic [CNT_W:0]   LANES_W = (CNT_W+1)'(LANES);

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       lane_q, lane_d, lane_cap;
  logic [WIDTH*LANES-1:0] pack_q, pack_d, pack_cap;
  logic                   inflight_q;
  logic                   flush_pend_q, flush_pend_d;
  logic                   out_valid_q, out_valid_d;
  logic [WIDTH*LANES-1:0] out_data_q, out_data_d;
  logic [LANES-1:0]       out_keep_q, out_keep_d;
  logic [7:0]             err_cnt_q;
  logic [CNT_W:0]         lane_sum;
  logic                   slot_free;
  logic                   rd_en;

  assign lane_sum  = {1'b0, lane_q} + {{CNT_W{1'b0}}, inflight_q};
  assign slot_free = ~out_valid_q | bus.out_ready_i;

  // A flush pulse also blocks the read in its own cycle so nothing new is requested.
  assign rd_en = ~rst_i & ~bus.fifo_empty_i & (state_q == ST_FILL) & ~bus.flush_i
                 & (lane_sum < LANES_W);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_FILL;
      lane_q       <= '0;
      pack_q       <= '0;
      inflight_q   <= 1'b0;
      flush_pend_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_keep_q   <= '0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      lane_q       <= lane_d;
      pack_q       <= pack_d;
      inflight_q   <= rd_en & ~bus.fifo_empty_i;
      flush_pend_q <= flush_pend_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_keep_q   <= out_keep_d;
      if (bus.fifo_error_i && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  always_comb begin
    state_d      = state_q;
    flush_pend_d = flush_pend_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_keep_d   = out_keep_q;
    lane_cap     = lane_q;
    pack_cap     = pack_q;

    if (inflight_q) begin
      for (int i = 0; i < LANES; i++) begin
        if (lane_q == CNT_W'(i)) pack_cap[i*WIDTH +: WIDTH] = bus.fifo_rdata_i;
      end
      lane_cap = lane_q + CNT_W'(1);
    end
    lane_d = lane_cap;
    pack_d = pack_cap;

    if (bus.out_ready_i) out_valid_d = 1'b0;

    // Full words leave in the cycle their last lane is captured when the slot allows.
    if ((lane_cap == LANES_C) && slot_free) begin
      out_data_d  = pack_cap;
      out_keep_d  = '1;
      out_valid_d = 1'b1;
      lane_d      = '0;
      pack_d      = '0;
    end

    case (state_q)
      ST_FILL: begin
        if (bus.flush_i) begin
          state_d      = ST_FLUSH;
          flush_pend_d = 1'b1;
        end
      end
      ST_FLUSH: begin
        if (!inflight_q) begin
          if (lane_q == '0) begin
            state_d      = ST_FILL;
            flush_pend_d = 1'b0;
          end else if (slot_free) begin
            if (flush_pend_q && (lane_q != LANES_C)) begin
              out_data_d  = pack_q;
              for (int i = 0; i < LANES; i++) out_keep_d[i] = (CNT_W'(i) < lane_q);
              out_valid_d = 1'b1;
              lane_d      = '0;
              pack_d      = '0;
            end
            state_d      = ST_FILL;
            flush_pend_d = 1'b0;
          end
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  assign bus.fifo_rd_en_o = rd_en;
  assign bus.out_valid_o  = out_valid_q;
  assign bus.out_data_o   = out_data_q;
  assign bus.out_keep_o   = out_keep_q;
  assign bus.err_cnt_o    = err_cnt_q;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer: behavioural 1-cycle-latency FIFO, scoreboard queue
// filled by the stimulus and drained by a negedge output monitor.
module tb_fifo_rd_packer;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_rd_packer_if #(.WIDTH(8), .LANES(4)) bus ();

  fifo_rd_packer #(.WIDTH(8), .LANES(4), .CNT_W(3)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  logic [7:0] mem[$];
  logic [7:0] wr_q[$];
  exp_t       exp_q[$];
  int         acc_cyc[$];
  int         checks    = 0;
  int         errors    = 0;
  int         rd_cnt    = 0;
  int         underflow = 0;
  int         cyc       = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic push_word(input logic [7:0] b);
    wr_q.push_back(b);
  endtask

  task automatic expect_word(input logic [31:0] d, input logic [3:0] k);
    exp_t e;
    e.d = d;
    e.k = k;
    exp_q.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic fifo_model();
    forever begin
      @(posedge clk);
      cyc++;
      if (bus.fifo_rd_en_o) begin
        rd_cnt++;
        if (mem.size() > 0) bus.fifo_rdata_i <= mem.pop_front();
        else underflow++;
      end
      while (wr_q.size() > 0) mem.push_back(wr_q.pop_front());
      bus.fifo_empty_i <= (mem.size() == 0);
    end
  endtask

  task automatic monitor();
    exp_t        e;
    logic        hold_prev = 1'b0;
    logic [31:0] d_prev = '0;
    logic [3:0]  k_prev = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_prev = 1'b0;
      end else begin
        if (hold_prev) begin
          checks++;
          if (!bus.out_valid_o || bus.out_data_o !== d_prev || bus.out_keep_o !== k_prev) begin
            errors++;
            $display("FAIL hold: got v=%0b d=0x%0h k=0x%0h required v=1 d=0x%0h k=0x%0h",
                     bus.out_valid_o, bus.out_data_o, bus.out_keep_o, d_prev, k_prev);
          end
        end
        if (bus.out_valid_o && bus.out_ready_i) begin
          checks++;
          acc_cyc.push_back(cyc);
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_word: got d=0x%0h k=0x%0h required none",
                     bus.out_data_o, bus.out_keep_o);
          end else begin
            e = exp_q.pop_front();
            if (bus.out_data_o !== e.d || bus.out_keep_o !== e.k) begin
              errors++;
              $display("FAIL out_word: got d=0x%0h k=0x%0h required d=0x%0h k=0x%0h",
                       bus.out_data_o, bus.out_keep_o, e.d, e.k);
            end
          end
        end
        hold_prev = bus.out_valid_o && !bus.out_ready_i;
        d_prev    = bus.out_data_o;
        k_prev    = bus.out_keep_o;
      end
    end
  endtask

  initial begin
    int r0;
    int n_acc;
    int seen;
    bus.fifo_empty_i = 1'b1;
    bus.fifo_rdata_i = '0;
    bus.fifo_error_i = 1'b0;
    bus.flush_i      = 1'b0;
    bus.out_ready_i  = 1'b1;
    fork
      fifo_model();
      monitor();
    join_none

    wait_cyc(3);
    chk("rst_rd_en", {31'd0, bus.fifo_rd_en_o}, 32'd0);
    chk("rst_valid", {31'd0, bus.out_valid_o}, 32'd0);
    chk("rst_data",  bus.out_data_o, 32'd0);
    chk("rst_keep",  {28'd0, bus.out_keep_o}, 32'd0);
    chk("rst_err",   {24'd0, bus.err_cnt_o}, 32'd0);
    rst = 1'b0;

    // single full word
    r0 = rd_cnt;
    expect_word(32'h44332211, 4'hF);
    push_word(8'h11); push_word(8'h22); push_word(8'h33); push_word(8'h44);
    wait_cyc(12);
    chk("t1_rd_pulses", rd_cnt - r0, 32'd4);
    chk("t1_delivered", exp_q.size(), 32'd0);

    // three streaming words
    for (int i = 1; i <= 12; i++) push_word(8'(i));
    expect_word(32'h04030201, 4'hF);
    expect_word(32'h08070605, 4'hF);
    expect_word(32'h0C0B0A09, 4'hF);
    wait_cyc(30);
    chk("t2_delivered", exp_q.size(), 32'd0);
    chk("t2_fifo_empty", {31'd0, bus.fifo_empty_i}, 32'd1);
    chk("t2_err_cnt", {24'd0, bus.err_cnt_o}, 32'd0);

    // backpressure: second word parks in the pack register
    bus.out_ready_i = 1'b0;
    r0 = rd_cnt;
    for (int i = 0; i < 8; i++) push_word(8'h21 + 8'(i));
    expect_word(32'h24232221, 4'hF);
    expect_word(32'h28272625, 4'hF);
    wait_cyc(20);
    chk("t3_rd_stop", rd_cnt - r0, 32'd8);
    chk("t3_valid_held", {31'd0, bus.out_valid_o}, 32'd1);
    chk("t3_data_held", bus.out_data_o, 32'h24232221);
    n_acc = acc_cyc.size();
    bus.out_ready_i = 1'b1;
    wait_cyc(5);
    chk("t3_delivered", exp_q.size(), 32'd0);
    if (acc_cyc.size() >= n_acc + 2) chk("t3_gap", acc_cyc[n_acc+1] - acc_cyc[n_acc], 32'd1);
    else chk("t3_accepts", acc_cyc.size() - n_acc, 32'd2);

    // partial flush, then an empty flush
    push_word(8'hA1); push_word(8'hA2); push_word(8'hA3);
    wait_cyc(10);
    expect_word(32'h00A3A2A1, 4'b0111);
    bus.flush_i = 1'b1;
    wait_cyc(1);
    bus.flush_i = 1'b0;
    wait_cyc(6);
    chk("t4_partial", exp_q.size(), 32'd0);
    n_acc = acc_cyc.size();
    bus.flush_i = 1'b1;
    wait_cyc(1);
    bus.flush_i = 1'b0;
    wait_cyc(6);
    chk("t4_empty_flush", acc_cyc.size(), n_acc);

    // flush one cycle after the second read request
    push_word(8'hB1); push_word(8'hB2);
    expect_word(32'h0000B2B1, 4'b0011);
    seen = 0;
    for (int i = 0; i < 20 && seen < 2; i++) begin
      @(negedge clk);
      if (bus.fifo_rd_en_o) seen++;
    end
    chk("t5_two_reads", seen, 32'd2);
    @(negedge clk);
    bus.flush_i = 1'b1;
    wait_cyc(1);
    bus.flush_i = 1'b0;
    wait_cyc(6);
    chk("t5_partial", exp_q.size(), 32'd0);

    // error counter and saturation
    bus.fifo_error_i = 1'b1;
    wait_cyc(10);
    chk("t6_err_10", {24'd0, bus.err_cnt_o}, 32'd10);
    wait_cyc(290);
    chk("t6_err_sat", {24'd0, bus.err_cnt_o}, 32'd255);
    bus.fifo_error_i = 1'b0;
    wait_cyc(2);
    chk("t6_err_hold", {24'd0, bus.err_cnt_o}, 32'd255);

    // asynchronous reset mid-pack
    push_word(8'hC1); push_word(8'hC2);
    wait_cyc(8);
    #2 rst = 1'b1;
    #1;
    chk("t7_rst_valid", {31'd0, bus.out_valid_o}, 32'd0);
    chk("t7_rst_data",  bus.out_data_o, 32'd0);
    chk("t7_rst_keep",  {28'd0, bus.out_keep_o}, 32'd0);
    chk("t7_rst_err",   {24'd0, bus.err_cnt_o}, 32'd0);
    chk("t7_rst_rd_en", {31'd0, bus.fifo_rd_en_o}, 32'd0);
    wait_cyc(2);
    rst = 1'b0;
    expect_word(32'hD4D3D2D1, 4'hF);
    push_word(8'hD1); push_word(8'hD2); push_word(8'hD3); push_word(8'hD4);
    wait_cyc(12);
    chk("t7_lane0_restart", exp_q.size(), 32'd0);
    chk("no_underflow", underflow, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
